stream_upsizer: RTL and testbench

- Consumer stage that sits directly downstream of a relay_station / FWFT FIFO read port.
- Packs RATIO narrow stream tokens into one wide token and writes it into a downstream FIFO write port.
- Honours the end-of-transaction (eot) bit carried in the top bit of every stream token.
- Flushes partially filled words on eot or on an idle timeout, so narrow producers can feed wide-datapath consumers without deadlock.

---
 rtl/stream_upsizer_if.sv | 26 ++
 rtl/stream_upsizer.sv | 117 +++++++++++
 tb/tb_stream_upsizer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_upsizer_if.sv
// Handshake bundle between the upsizer and its upstream FWFT read port / downstream FIFO write port.
// The master side is the upsizer (issues reads and writes); the slave side is the FIFO pair around it.
interface stream_upsizer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int RATIO      = 4
);
  localparam int CNT_WIDTH = $clog2(RATIO + 1);
  localparam int OUT_WIDTH = RATIO * DATA_WIDTH + CNT_WIDTH + 1;

  logic                  in_empty_n;
  logic                  in_read;
  logic [DATA_WIDTH:0]   in_dout;
  logic                  out_full_n;
  logic                  out_write;
  logic [OUT_WIDTH-1:0]  out_din;

  modport master (
    input  in_empty_n, in_dout, out_full_n,
    output in_read, out_write, out_din
  );

  modport slave (
    output in_empty_n, in_dout, out_full_n,
    input  in_read, out_write, out_din
  );
endinterface

// File: rtl/stream_upsizer.sv
// Packs RATIO narrow {eot, payload} tokens into one {eot, count, lanes} word, flushing partial
// words on eot or after FLUSH_TIMEOUT idle cycles so narrow producers never deadlock wide consumers.
module stream_upsizer #(
  parameter int DATA_WIDTH    = 32,
  parameter int RATIO         = 4,
  parameter int CNT_WIDTH     = $clog2(RATIO + 1),
  parameter int FLUSH_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  stream_upsizer_if.master bus
);
  localparam int ACC_WIDTH  = RATIO * DATA_WIDTH;
  localparam int OUT_WIDTH  = ACC_WIDTH + CNT_WIDTH + 1;
  localparam int LANE_WIDTH = $clog2(RATIO);
  localparam int TMR_WIDTH  = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
  localparam logic [LANE_WIDTH-1:0] LAST_LANE = LANE_WIDTH'(RATIO - 1);
  localparam logic [TMR_WIDTH-1:0]  TMR_LIMIT = TMR_WIDTH'(FLUSH_TIMEOUT);
  localparam logic [CNT_WIDTH-1:0]  FULL_CNT  = CNT_WIDTH'(RATIO);

  logic [ACC_WIDTH-1:0]  acc_reg, acc_next, acc_merged;
  logic [LANE_WIDTH-1:0] lane_reg, lane_next;
  logic [OUT_WIDTH-1:0]  obuf_reg, obuf_next;
  logic                  ovalid_reg, ovalid_next;
  logic [TMR_WIDTH-1:0]  timer_reg, timer_next;

  logic                  tok_eot, partial, completes, ofree;
  logic                  timeout_hit, tmo_flush, do_flush, accept, write;
  logic [DATA_WIDTH-1:0] payload;

  assign payload   = bus.in_dout[DATA_WIDTH-1:0];
  assign tok_eot   = bus.in_dout[DATA_WIDTH];
  assign partial   = (lane_reg != '0);
  assign completes = (lane_reg == LAST_LANE);
  assign ofree     = ~ovalid_reg | bus.out_full_n;

  assign timeout_hit = (FLUSH_TIMEOUT > 0) && partial && (timer_reg == TMR_LIMIT);
  assign tmo_flush   = timeout_hit & ofree;
  // An eot arriving on a partial word first pushes the partial out; the eot itself stays queued.
  assign do_flush    = tmo_flush | (bus.in_empty_n & tok_eot & partial & ofree);

  always_comb begin
    accept = 1'b0;
    if (!reset && bus.in_empty_n && !tmo_flush) begin
      if (tok_eot) begin
        accept = !partial && ofree;
      end else begin
        accept = !completes || ofree;
      end
    end
  end

  assign write         = ovalid_reg & bus.out_full_n & ~reset;
  assign bus.in_read   = accept;
  assign bus.out_write = write;
  assign bus.out_din   = obuf_reg;

  // Incoming payload lands in the lane selected by lane_reg; lane 0 sits at the LSBs.
  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
      assign acc_merged[gi*DATA_WIDTH +: DATA_WIDTH] =
        (lane_reg == LANE_WIDTH'(gi)) ? payload : acc_reg[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  always_comb begin
    acc_next    = acc_reg;
    lane_next   = lane_reg;
    obuf_next   = obuf_reg;
    ovalid_next = ovalid_reg & ~write;
    timer_next  = timer_reg;

    if (do_flush) begin
      // Unused lanes are already zero because acc is cleared whenever a word leaves.
      obuf_next   = {1'b0, CNT_WIDTH'(lane_reg), acc_reg};
      ovalid_next = 1'b1;
      lane_next   = '0;
      acc_next    = '0;
    end else if (accept) begin
      if (tok_eot) begin
        obuf_next   = {1'b1, {CNT_WIDTH{1'b0}}, {ACC_WIDTH{1'b0}}};
        ovalid_next = 1'b1;
      end else if (completes) begin
        obuf_next   = {1'b0, FULL_CNT, acc_merged};
        ovalid_next = 1'b1;
        lane_next   = '0;
        acc_next    = '0;
      end else begin
        acc_next  = acc_merged;
        lane_next = lane_reg + 1'b1;
      end
    end

    // Idle timer saturates at the limit so a blocked flush fires as soon as the slot frees.
    if (FLUSH_TIMEOUT == 0 || !partial || accept || do_flush) begin
      timer_next = '0;
    end else if (!bus.in_empty_n && timer_reg != TMR_LIMIT) begin
      timer_next = timer_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg    <= '0;
      lane_reg   <= '0;
      obuf_reg   <= '0;
      ovalid_reg <= 1'b0;
      timer_reg  <= '0;
    end else begin
      acc_reg    <= acc_next;
      lane_reg   <= lane_next;
      obuf_reg   <= obuf_next;
      ovalid_reg <= ovalid_next;
      timer_reg  <= timer_next;
    end
  end
endmodule

// File: tb/tb_stream_upsizer.sv
// Bench for stream_upsizer: FWFT source model, token scoreboard unpacked by the count field,
// and directed checks of packing, eot flush, backpressure, timeout, reset and random stalls.
module tb_stream_upsizer;
  localparam int DW  = 32;
  localparam int R   = 4;
  localparam int CW  = $clog2(R + 1);
  localparam int OW  = R * DW + CW + 1;
  localparam int TMO = 16;

  typedef logic [DW:0]   tok_t;
  typedef logic [OW-1:0] word_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  stream_upsizer_if #(.DATA_WIDTH(DW), .RATIO(R)) bus ();

  stream_upsizer #(
    .DATA_WIDTH(DW),
    .RATIO(R),
    .FLUSH_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int    err_cnt = 0;
  int    chk_cnt = 0;
  int    cyc = 0;
  int    eot_in = 0;
  int    eot_out = 0;
  tok_t  src_q[$];
  tok_t  sb[$];
  word_t out_log[$];
  int    out_cyc[$];
  int    acc_cyc[$];
  logic  src_en = 1'b0;
  logic  full_ctl = 1'b1;
  logic  rand_mode = 1'b0;
  logic  last_rd, last_wr;
  word_t last_dout;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic word_t make_word(input logic e, input int cnt,
                                      input logic [DW-1:0] l3, l2, l1, l0);
    return {e, CW'(cnt), l3, l2, l1, l0};
  endfunction

  task automatic drive();
    bus.in_empty_n = src_en && (src_q.size() > 0);
    bus.in_dout    = (src_q.size() > 0) ? src_q[0] : '0;
    bus.out_full_n = full_ctl;
  endtask

  task automatic clear_logs();
    out_log.delete();
    out_cyc.delete();
    acc_cyc.delete();
  endtask

  // Unpacks one written word against the token scoreboard.
  task automatic check_word(input word_t w);
    logic          e;
    logic [CW-1:0] cnt;
    logic [DW-1:0] ln;
    tok_t          t;
    e   = w[OW-1];
    cnt = w[OW-2 -: CW];
    $display("write cyc=%0d eot=%0b cnt=%0d lanes=%h", cyc, e, cnt, w[R*DW-1:0]);
    if (e) begin
      eot_out++;
      check("eot_cnt", cnt, 0);
      check("eot_data", w[R*DW-1:0], 0);
      t = '0;
      if (sb.size() > 0) t = sb.pop_front();
      check("eot_order", t[DW], 1);
    end else begin
      check("cnt_range", (cnt >= 1 && cnt <= R), 1);
      for (int i = 0; i < R; i++) begin
        ln = w[i*DW +: DW];
        if (i < int'(cnt)) begin
          if (sb.size() > 0) begin
            t = sb.pop_front();
            check("lane_eot", t[DW], 0);
            check("lane_data", ln, t[DW-1:0]);
          end else begin
            check("sb_underrun", sb.size(), 1);
          end
        end else begin
          check("lane_unused", ln, 0);
        end
      end
    end
  endtask

  // One clock: sample at negedge, act after the posedge.
  task automatic step();
    logic  fi, fo, en;
    word_t w;
    @(negedge clk);
    cyc++;
    fi = bus.in_read;
    fo = bus.out_write;
    en = bus.in_empty_n;
    w  = bus.out_din;
    last_rd   = fi;
    last_wr   = fo;
    last_dout = w;
    if (fi) check("rd_when_empty", en, 1);
    if (fo) check("wr_when_full", bus.out_full_n, 1);
    if (fo) begin
      out_log.push_back(w);
      out_cyc.push_back(cyc);
      check_word(w);
    end
    if (fi && en) begin
      sb.push_back(bus.in_dout);
      acc_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    if (fi && en && src_q.size() > 0) void'(src_q.pop_front());
    if (rand_mode) begin
      src_en   = ($urandom_range(0, 9) < 7);
      full_ctl = ($urandom_range(0, 9) < 7);
    end
    drive();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((src_q.size() > 0 || sb.size() > 0) && n < budget) begin
      step();
      n++;
    end
    check("drain_done", (src_q.size() == 0 && sb.size() == 0), 1);
    repeat (2) step();
  endtask

  initial begin
    int n;
    logic e;

    // Reset state
    drive();
    repeat (3) begin
      step();
      check("rst_out_write", last_wr, 0);
      check("rst_in_read", last_rd, 0);
    end
    reset = 1'b0;
    drive();
    step();
    check("rst_out_din", last_dout, 0);
    check("rst_idle_write", last_wr, 0);

    // 1: streaming pack
    clear_logs();
    for (int i = 1; i <= 8; i++) src_q.push_back({1'b0, 32'(i)});
    src_en = 1'b1;
    full_ctl = 1'b1;
    drive();
    drain(200);
    check("t1_nwords", out_log.size(), 2);
    if (out_log.size() >= 2) begin
      check("t1_word0", out_log[0], make_word(1'b0, 4, 32'h4, 32'h3, 32'h2, 32'h1));
      check("t1_word1", out_log[1], make_word(1'b0, 4, 32'h8, 32'h7, 32'h6, 32'h5));
    end
    if (acc_cyc.size() >= 8 && out_cyc.size() >= 1) begin
      check("t1_latency", out_cyc[0] - acc_cyc[3], 1);
      check("t1_rate", acc_cyc[7] - acc_cyc[0], 7);
    end

    // 2: eot flush
    clear_logs();
    src_q.push_back({1'b0, 32'hA});
    src_q.push_back({1'b0, 32'hB});
    src_q.push_back({1'b1, 32'hDEAD});
    drive();
    drain(200);
    check("t2_nwords", out_log.size(), 2);
    if (out_log.size() >= 2 && acc_cyc.size() >= 3) begin
      check("t2_partial", out_log[0], make_word(1'b0, 2, 32'h0, 32'h0, 32'hB, 32'hA));
      check("t2_eot_word", out_log[1], make_word(1'b1, 0, 32'h0, 32'h0, 32'h0, 32'h0));
      check("t2_eot_pop", acc_cyc[2], out_cyc[0]);
      check("t2_eot_lat", out_cyc[1] - out_cyc[0], 1);
    end

    // 3: backpressure
    clear_logs();
    full_ctl = 1'b0;
    for (int i = 0; i < 8; i++) src_q.push_back({1'b0, 32'h21 + 32'(i)});
    drive();
    repeat (20) step();
    check("t3_accepts", acc_cyc.size(), 7);
    check("t3_held", out_log.size(), 0);
    full_ctl = 1'b1;
    drive();
    drain(200);
    check("t3_nwords", out_log.size(), 2);
    if (out_log.size() >= 2) begin
      check("t3_word0", out_log[0], make_word(1'b0, 4, 32'h24, 32'h23, 32'h22, 32'h21));
      check("t3_word1", out_log[1], make_word(1'b0, 4, 32'h28, 32'h27, 32'h26, 32'h25));
    end

    // 4: idle timeout
    clear_logs();
    src_q.push_back({1'b0, 32'h55});
    drive();
    drain(200);
    check("t4_nwords", out_log.size(), 1);
    if (out_log.size() >= 1 && acc_cyc.size() >= 1) begin
      check("t4_word", out_log[0], make_word(1'b0, 1, 32'h0, 32'h0, 32'h0, 32'h55));
      check("t4_latency", out_cyc[0] - acc_cyc[0], TMO + 2);
    end
    repeat (40) step();
    check("t4_no_extra", out_log.size(), 1);

    // 5: reset mid-packet with a pending word held back
    clear_logs();
    full_ctl = 1'b0;
    for (int i = 0; i < 4; i++) src_q.push_back({1'b0, 32'h41 + 32'(i)});
    for (int i = 0; i < 3; i++) src_q.push_back({1'b0, 32'h31 + 32'(i)});
    drive();
    n = 0;
    while (acc_cyc.size() < 7 && n < 50) begin
      step();
      n++;
    end
    check("t5_pre_accepts", acc_cyc.size(), 7);
    for (int i = 0; i < 4; i++) src_q.push_back({1'b0, 32'h10 + 32'(i)});
    full_ctl = 1'b1;
    reset = 1'b1;
    drive();
    step();
    check("t5_rst_in_read", last_rd, 0);
    check("t5_rst_out_write", last_wr, 0);
    reset = 1'b0;
    sb.delete();
    clear_logs();
    drive();
    drain(200);
    check("t5_nwords", out_log.size(), 1);
    if (out_log.size() >= 1)
      check("t5_word", out_log[0], make_word(1'b0, 4, 32'h13, 32'h12, 32'h11, 32'h10));

    // 6: random stalls and eots
    clear_logs();
    eot_in = 0;
    eot_out = 0;
    for (int i = 0; i < 1000; i++) begin
      e = ($urandom_range(0, 7) == 0);
      src_q.push_back({e, 32'($urandom)});
      if (e) eot_in++;
    end
    rand_mode = 1'b1;
    drive();
    n = 0;
    while (src_q.size() > 0 && n < 30000) begin
      step();
      n++;
    end
    rand_mode = 1'b0;
    src_en = 1'b1;
    full_ctl = 1'b1;
    drive();
    drain(500);
    check("t6_src_done", src_q.size(), 0);
    check("t6_sb_empty", sb.size(), 0);
    check("t6_eot_match", eot_out, eot_in);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
